// File: rtl/prio_event_encoder_if.sv
// Handshake bundle between prio_event_encoder and its consumer.
// master: encoder side (drives y/valid/pending/ovf); slave: consumer side.
// Carries mask only when PRIO_EVENT_ENCODER_MASK_EN is defined.
interface prio_event_encoder_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic [N-1:0] a;
    logic         ready;
    logic         ovf_clr;
`ifdef PRIO_EVENT_ENCODER_MASK_EN
    logic [N-1:0] mask;
`endif
    logic [W-1:0] y;
    logic         valid;
    logic [N-1:0] pending;
    logic         ovf;

`ifdef PRIO_EVENT_ENCODER_MASK_EN
    modport master (
        input  a, ready, ovf_clr, mask,
        output y, valid, pending, ovf
    );
    modport slave (
        output a, ready, ovf_clr, mask,
        input  y, valid, pending, ovf
    );
`else
    modport master (
        input  a, ready, ovf_clr,
        output y, valid, pending, ovf
    );
    modport slave (
        output a, ready, ovf_clr,
        input  y, valid, pending, ovf
    );
`endif
endinterface

// File: rtl/prio_event_encoder.sv
// Registered priority encoder: sticky pending capture, highest index
// presented over valid/ready, accepted bit cleared, sticky overflow flag.
// Ports: clk, reset_n (async, active-low), bus (prio_event_encoder_if.master:
//   a, ready, ovf_clr, [mask] in; y, valid, pending, ovf out).
// Optional: PRIO_EVENT_ENCODER_MASK_EN adds bus.mask selection exclusion.
module prio_event_encoder #(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    prio_event_encoder_if.master   bus
);
    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] y_q, y_d;
    logic [N-1:0] pending_q, pending_d;
    logic         ovf_q, ovf_d;

    logic [N-1:0] acc_mask;
    logic [N-1:0] next_pend;
    logic [N-1:0] sel_mask;
    logic [N-1:0] cand;

    function automatic logic [W-1:0] msb_idx(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = W'(i);
        end
        return r;
    endfunction

`ifdef PRIO_EVENT_ENCODER_MASK_EN
    assign sel_mask = bus.mask;
`else
    assign sel_mask = '0;
`endif

    always_comb begin
        acc_mask  = '0;
        if (state_q == PRESENT && bus.ready) begin
            acc_mask = N'(1) << y_q;
        end
        // Remaining pending after the accept, before this cycle's captures
        next_pend = pending_q & ~acc_mask;
        // Set wins over accept-clear on the same bit
        pending_d = next_pend | bus.a;
        ovf_d     = (|(bus.a & next_pend)) | (ovf_q & ~bus.ovf_clr);

        state_d = state_q;
        y_d     = y_q;
        cand    = '0;
        unique case (state_q)
            IDLE: begin
                cand = pending_q & ~sel_mask;
                if (|cand) begin
                    y_d     = msb_idx(cand);
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.ready) begin
                    cand = next_pend & ~sel_mask;
                    if (|cand) begin
                        y_d = msb_idx(cand);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            y_q       <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.y       = y_q;
    assign bus.valid   = (state_q == PRESENT);
    assign bus.pending = pending_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_prio_event_encoder.sv
// Bench for prio_event_encoder: directed literal checks plus random
// stimulus compared every cycle against a behavioural model.
module tb_prio_event_encoder;
    localparam int N = 8;
    localparam int W = $clog2(N);

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    prio_event_encoder_if #(.N(N)) bus ();

    prio_event_encoder #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [N-1:0] cur_mask;
`ifdef PRIO_EVENT_ENCODER_MASK_EN
    assign bus.mask = cur_mask;
`endif

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Behavioural model: a set of pending events, whether one is
    // currently on offer, which one, and the lost-event flag.
    bit [N-1:0] m_pend;
    bit         m_busy;
    int         m_y;
    bit         m_ovf;
    bit [N-1:0] m_rem;
    bit         m_lost;
    bit         m_taken;
    int         m_h;

    function automatic int highest(input bit [N-1:0] v,
                                   input bit [N-1:0] excl);
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i] && !excl[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pend = '0;
            m_busy = 1'b0;
            m_y    = 0;
            m_ovf  = 1'b0;
        end else begin
            m_taken = m_busy && bus.ready;
            m_rem   = m_pend;
            if (m_taken) m_rem[m_y] = 1'b0;
            m_lost = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (bus.a[i] && m_rem[i]) m_lost = 1'b1;
            end
            if (m_taken) begin
                m_h = highest(m_rem, cur_mask);
                if (m_h >= 0) m_y = m_h;
                else m_busy = 1'b0;
            end else if (!m_busy) begin
                m_h = highest(m_pend, cur_mask);
                if (m_h >= 0) begin
                    m_busy = 1'b1;
                    m_y    = m_h;
                end
            end
            m_pend = m_rem | bus.a;
            m_ovf  = m_lost || (m_ovf && !bus.ovf_clr);
        end
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            check("cyc_y", 32'(bus.y), 32'(m_y));
            check("cyc_valid", 32'(bus.valid), 32'(m_busy));
            check("cyc_pending", 32'(bus.pending), 32'(m_pend));
            check("cyc_ovf", 32'(bus.ovf), 32'(m_ovf));
        end
    end

    task automatic cyc(input logic [N-1:0] av, input logic r,
                       input logic c);
        bus.a       = av;
        bus.ready   = r;
        bus.ovf_clr = c;
        @(negedge clk);
    endtask

    task automatic chk4(input string name, input int y, input int v,
                        input int p, input int o);
        check({name, "_y"}, 32'(bus.y), 32'(y));
        check({name, "_valid"}, 32'(bus.valid), 32'(v));
        check({name, "_pending"}, 32'(bus.pending), 32'(p));
        check({name, "_ovf"}, 32'(bus.ovf), 32'(o));
    endtask

    initial begin
        reset_n     = 1'b0;
        bus.a       = '0;
        bus.ready   = 1'b0;
        bus.ovf_clr = 1'b0;
        cur_mask    = '0;
        repeat (2) @(negedge clk);
        chk4("in_reset", 0, 0, 0, 0);
        reset_n = 1'b1;
        cyc(8'h00, 0, 0);
        chk4("post_reset", 0, 0, 0, 0);

        cyc(8'h24, 0, 0);
        chk4("lat_edge1", 0, 0, 8'h24, 0);
        cyc(8'h00, 0, 0);
        chk4("lat_edge2", 5, 1, 8'h24, 0);

        cyc(8'h00, 1, 0);
        chk4("b2b_first", 2, 1, 8'h04, 0);
        cyc(8'h80, 0, 0);
        chk4("hold_stable", 2, 1, 8'h84, 0);
        cyc(8'h00, 1, 0);
        chk4("after_hold", 7, 1, 8'h80, 0);
        cyc(8'h00, 1, 0);
        chk4("drained", 7, 0, 8'h00, 0);

        cyc(8'h08, 0, 0);
        chk4("ovf_cap", 7, 0, 8'h08, 0);
        cyc(8'h08, 0, 0);
        chk4("ovf_set", 3, 1, 8'h08, 1);
        cyc(8'h08, 0, 1);
        chk4("ovf_setwins", 3, 1, 8'h08, 1);
        cyc(8'h00, 0, 1);
        chk4("ovf_clr", 3, 1, 8'h08, 0);
        cyc(8'h00, 1, 0);
        chk4("ovf_done", 3, 0, 8'h00, 0);

        cyc(8'h10, 0, 0);
        cyc(8'h00, 0, 0);
        chk4("rearm_pres", 4, 1, 8'h10, 0);
        cyc(8'h10, 1, 0);
        chk4("rearm_acc", 4, 0, 8'h10, 0);
        cyc(8'h00, 0, 0);
        chk4("rearm_again", 4, 1, 8'h10, 0);
        cyc(8'h00, 1, 0);

`ifdef PRIO_EVENT_ENCODER_MASK_EN
        cur_mask = 8'h80;
        cyc(8'h81, 0, 0);
        cyc(8'h00, 0, 0);
        chk4("mask_sel", 0, 1, 8'h81, 0);
        cur_mask = 8'h00;
        cyc(8'h00, 1, 0);
        chk4("unmask_sel", 7, 1, 8'h80, 0);
        cyc(8'h00, 1, 0);
`endif

        cyc(8'hA5, 0, 0);
        cyc(8'h00, 0, 0);
        chk4("pre_areset", 7, 1, 8'hA5, 0);
        #2 reset_n = 1'b0;
        #1 chk4("areset", 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int k = 0; k < 3000; k++) begin
            if (k % 700 == 350) begin
                #3 reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
`ifdef PRIO_EVENT_ENCODER_MASK_EN
            cur_mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
`endif
            cyc(($urandom_range(0, 2) == 0) ? N'($urandom & $urandom) : '0,
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 15) == 0);
        end
        cur_mask = '0;
        repeat (4) cyc(8'h00, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
